// File: rtl/bitonic_frame_loader.sv
// Frame loader for a bitonic sorter: gathers a stream of elements into a
// DATALENGTH-wide frame, pads unused slots, and presents the frame through a
// single output register with a valid/ready handshake. A second frame can be
// parked in the fill buffer (HOLD) while the output register is still occupied.
module bitonic_frame_loader #(
  parameter int                   DATAWIDTH  = 8,
  parameter int                   DATALENGTH = 16,
  parameter logic [DATAWIDTH-1:0] PAD_VALUE  = '0
) (
  input  logic                             clk_i,
  input  logic                             rstn_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [DATAWIDTH-1:0]             in_data_i,
  input  logic                             in_last_i,
  output logic                             vec_valid_o,
  input  logic                             vec_ready_i,
  output logic [DATAWIDTH-1:0]             vec_o [DATALENGTH-1:0],
  output logic [$clog2(DATALENGTH):0]      vec_count_o,
  output logic                             vec_last_o
);

  localparam int AW = $clog2(DATALENGTH);
  localparam int CW = AW + 1;

  typedef enum logic {FILL, HOLD} state_t;

  state_t               state;
  logic [DATAWIDTH-1:0] fill_q [DATALENGTH];
  logic [CW-1:0]        cnt;
  logic                 hold_last;
  logic                 ready_q;

  logic                 accept, complete, out_free, load;
  logic [DATAWIDTH-1:0] frame [DATALENGTH];
  logic [CW-1:0]        frame_cnt;
  logic                 frame_last;

  // ready_q is only ever high in FILL, so it also gates acceptance by state
  assign in_ready_o = ready_q;
  assign accept     = in_valid_i & ready_q;
  assign complete   = accept & (in_last_i | (cnt == CW'(DATALENGTH - 1)));
  assign out_free   = ~vec_valid_o | vec_ready_i;
  // In HOLD the output register is always occupied, so ready alone frees it
  assign load       = (state == FILL) ? (complete & out_free) : vec_ready_i;

  // Assemble the outgoing frame: stored slots below the count, the completing
  // element bypassed straight in when loading from FILL, padding above.
  always_comb begin
    for (int i = 0; i < DATALENGTH; i++) begin
      if (CW'(i) < cnt)                       frame[i] = fill_q[i];
      else if (state == FILL && CW'(i) == cnt) frame[i] = in_data_i;
      else                                     frame[i] = PAD_VALUE;
    end
    frame_cnt  = (state == FILL) ? cnt + 1'b1 : cnt;
    frame_last = (state == FILL) ? in_last_i : hold_last;
  end

  // Fill buffer storage; stale contents are harmless because reads are
  // masked by the count, so no reset is needed here.
  always_ff @(posedge clk_i) begin
    if (accept) fill_q[cnt[AW-1:0]] <= in_data_i;
  end

  // Fill FSM, output register and handshake flags
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= FILL;
      cnt         <= '0;
      hold_last   <= 1'b0;
      ready_q     <= 1'b0;
      vec_valid_o <= 1'b0;
      vec_count_o <= '0;
      vec_last_o  <= 1'b0;
      for (int i = 0; i < DATALENGTH; i++) vec_o[i] <= PAD_VALUE;
    end else begin
      if (vec_ready_i) vec_valid_o <= 1'b0;
      if (load) begin
        for (int i = 0; i < DATALENGTH; i++) vec_o[i] <= frame[i];
        vec_count_o <= frame_cnt;
        vec_last_o  <= frame_last;
        vec_valid_o <= 1'b1;
        cnt         <= '0;
        state       <= FILL;
        ready_q     <= 1'b1;
      end else if (complete) begin
        // output busy: park the finished frame in the fill buffer
        cnt       <= cnt + 1'b1;
        hold_last <= in_last_i;
        state     <= HOLD;
        ready_q   <= 1'b0;
      end else begin
        if (accept) cnt <= cnt + 1'b1;
        ready_q <= (state == FILL);
      end
    end
  end

endmodule

// File: tb/tb_bitonic_frame_loader.sv
// Directed bench for bitonic_frame_loader (16 x 8-bit, non-zero pad value so
// padding is distinguishable from zero data).
module tb_bitonic_frame_loader;

  localparam int          DW  = 8;
  localparam int          DL  = 16;
  localparam logic [7:0]  PAD = 8'h5A;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid, in_ready, in_last;
  logic [DW-1:0] in_data;
  logic          vec_valid, vec_ready, vec_last;
  logic [DW-1:0] vec [DL-1:0];
  logic [4:0]    vec_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bitonic_frame_loader #(.DATAWIDTH(DW), .DATALENGTH(DL), .PAD_VALUE(PAD)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_last_i(in_last),
    .vec_valid_o(vec_valid), .vec_ready_i(vec_ready), .vec_o(vec),
    .vec_count_o(vec_count), .vec_last_o(vec_last)
  );

  // advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; vec_ready = 1'b0; idle();
    step(); step();
    n_chk++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_chk++; if (vec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vec_valid: got %b want 0", vec_valid); end
    n_chk++; if (vec_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", vec_count); end
    n_chk++; if (vec_last !== 1'b0)  begin n_fail++; $display("FAIL reset_last: got %b want 0", vec_last); end
    for (int i = 0; i < DL; i++) begin
      n_chk++; if (vec[i] !== PAD) begin n_fail++; $display("FAIL reset_slot%0d: got %h want %h", i, vec[i], PAD); end
    end
    rstn = 1'b1;
    step();
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
  endtask

  // 16 elements 1..16, optionally with last on the 16th
  task automatic test_full(input logic with_last);
    vec_ready = 1'b1;
    for (int k = 0; k < DL; k++) begin
      in_valid = 1'b1; in_data = DW'(k + 1); in_last = with_last && (k == DL - 1);
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_in_ready k=%0d: got %b want 1", k, in_ready); end
      step();
      if (k < DL - 1) begin
        n_chk++; if (vec_valid !== 1'b0) begin n_fail++; $display("FAIL full_early_valid k=%0d: got %b want 0", k, vec_valid); end
      end
    end
    idle();
    n_chk++; if (vec_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid: got %b want 1", vec_valid); end
    n_chk++; if (vec_count !== 5'd16) begin n_fail++; $display("FAIL full_count: got %0d want 16", vec_count); end
    n_chk++; if (vec_last !== with_last) begin n_fail++; $display("FAIL full_last: got %b want %b", vec_last, with_last); end
    for (int i = 0; i < DL; i++) begin
      n_chk++; if (vec[i] !== DW'(i + 1)) begin n_fail++; $display("FAIL full_slot%0d: got %h want %h", i, vec[i], DW'(i + 1)); end
    end
    step();
    n_chk++; if (vec_valid !== 1'b0) begin n_fail++; $display("FAIL full_pulse: got %b want 0", vec_valid); end
  endtask

  task automatic test_short();
    logic [7:0] vals [5];
    vals = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5};
    vec_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = vals[k]; in_last = (k == 4);
      step();
    end
    idle();
    n_chk++; if (vec_valid !== 1'b1) begin n_fail++; $display("FAIL short_valid: got %b want 1", vec_valid); end
    n_chk++; if (vec_count !== 5'd5) begin n_fail++; $display("FAIL short_count: got %0d want 5", vec_count); end
    n_chk++; if (vec_last !== 1'b1)  begin n_fail++; $display("FAIL short_last: got %b want 1", vec_last); end
    for (int i = 0; i < DL; i++) begin
      n_chk++;
      if (vec[i] !== ((i < 5) ? vals[i] : PAD)) begin
        n_fail++; $display("FAIL short_slot%0d: got %h want %h", i, vec[i], (i < 5) ? vals[i] : PAD);
      end
    end
    step();
  endtask

  task automatic test_single();
    vec_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b1;
    step(); idle();
    n_chk++; if (vec_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", vec_valid); end
    n_chk++; if (vec_count !== 5'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", vec_count); end
    n_chk++; if (vec_last !== 1'b1)  begin n_fail++; $display("FAIL single_last: got %b want 1", vec_last); end
    n_chk++; if (vec[0] !== 8'hAA)   begin n_fail++; $display("FAIL single_slot0: got %h want aa", vec[0]); end
    for (int i = 1; i < DL; i++) begin
      n_chk++; if (vec[i] !== PAD) begin n_fail++; $display("FAIL single_slot%0d: got %h want %h", i, vec[i], PAD); end
    end
    step();
  endtask

  // 48 elements streamed with no gaps; frames appear every 16 cycles
  task automatic test_back_to_back();
    int frames = 0;
    vec_ready = 1'b1;
    for (int k = 0; k < 48; k++) begin
      in_valid = 1'b1; in_data = DW'(k * 3); in_last = 1'b0;
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready k=%0d: got %b want 1", k, in_ready); end
      step();
      n_chk++;
      if (vec_valid !== (k % 16 == 15)) begin
        n_fail++; $display("FAIL b2b_valid k=%0d: got %b want %b", k, vec_valid, (k % 16 == 15));
      end
      if (k % 16 == 15) begin
        frames++;
        n_chk++; if (vec[0] !== DW'((k - 15) * 3)) begin n_fail++; $display("FAIL b2b_slot0 k=%0d: got %h want %h", k, vec[0], DW'((k - 15) * 3)); end
        n_chk++; if (vec[15] !== DW'(k * 3)) begin n_fail++; $display("FAIL b2b_slot15 k=%0d: got %h want %h", k, vec[15], DW'(k * 3)); end
        n_chk++; if (vec_count !== 5'd16) begin n_fail++; $display("FAIL b2b_count k=%0d: got %0d want 16", k, vec_count); end
      end
    end
    idle();
    n_chk++; if (frames !== 3) begin n_fail++; $display("FAIL b2b_frames: got %0d want 3", frames); end
    step();
  endtask

  // Backpressure: frame 1 held in output, frame 2 parked in HOLD
  task automatic test_hold();
    vec_ready = 1'b0;
    for (int k = 0; k < 32; k++) begin
      in_valid = 1'b1; in_data = DW'(100 + k); in_last = 1'b0;
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_fill_ready k=%0d: got %b want 1", k, in_ready); end
      step();
    end
    // keep offering element 32; it must not be taken while HOLD
    in_data = 8'd132;
    for (int c = 0; c < 3; c++) begin
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready c=%0d: got %b want 0", c, in_ready); end
      n_chk++; if (vec_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid c=%0d: got %b want 1", c, vec_valid); end
      n_chk++; if (vec[0] !== 8'd100 || vec[15] !== 8'd115) begin n_fail++; $display("FAIL hold_stable c=%0d: got %h/%h want 64/73", c, vec[0], vec[15]); end
      n_chk++; if (vec_count !== 5'd16) begin n_fail++; $display("FAIL hold_count c=%0d: got %0d want 16", c, vec_count); end
      step();
    end
    vec_ready = 1'b1; step(); vec_ready = 1'b0;
    n_chk++; if (vec_valid !== 1'b1) begin n_fail++; $display("FAIL hold_release_valid: got %b want 1", vec_valid); end
    n_chk++; if (vec[0] !== 8'd116 || vec[15] !== 8'd131) begin n_fail++; $display("FAIL hold_release_data: got %h/%h want 74/83", vec[0], vec[15]); end
    n_chk++; if (vec_last !== 1'b0) begin n_fail++; $display("FAIL hold_release_last: got %b want 0", vec_last); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_ready: got %b want 1", in_ready); end
    // remaining 8 of the 40, last on the final one: a short frame through HOLD
    for (int k = 32; k < 40; k++) begin
      in_valid = 1'b1; in_data = DW'(100 + k); in_last = (k == 39);
      step();
    end
    idle();
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold2_in_ready: got %b want 0", in_ready); end
    vec_ready = 1'b1; step();
    n_chk++; if (vec_count !== 5'd8) begin n_fail++; $display("FAIL hold2_count: got %0d want 8", vec_count); end
    n_chk++; if (vec_last !== 1'b1) begin n_fail++; $display("FAIL hold2_last: got %b want 1", vec_last); end
    n_chk++; if (vec[7] !== 8'd139) begin n_fail++; $display("FAIL hold2_slot7: got %h want 8b", vec[7]); end
    n_chk++; if (vec[8] !== PAD) begin n_fail++; $display("FAIL hold2_slot8: got %h want %h", vec[8], PAD); end
    step();
    n_chk++; if (vec_valid !== 1'b0) begin n_fail++; $display("FAIL hold2_drain: got %b want 0", vec_valid); end
  endtask

  task automatic test_reset_midframe();
    vec_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1; in_data = DW'(8'h30 + k); in_last = 1'b0;
      step();
    end
    idle();
    rstn = 1'b0; #1;
    n_chk++; if (vec_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got v=%b r=%b want 0/0", vec_valid, in_ready); end
    n_chk++; if (vec[0] !== PAD || vec_count !== 5'd0) begin n_fail++; $display("FAIL midrst_out: got %h/%0d want %h/0", vec[0], vec_count, PAD); end
    step(); rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_chk++; if (vec_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale c=%0d: got %b want 0", c, vec_valid); end
    end
    for (int k = 0; k < DL; k++) begin
      in_valid = 1'b1; in_data = DW'(8'h60 + k); in_last = 1'b0;
      step();
    end
    idle();
    n_chk++; if (vec_valid !== 1'b1 || vec_count !== 5'd16) begin n_fail++; $display("FAIL midrst_frame: got v=%b n=%0d want 1/16", vec_valid, vec_count); end
    for (int i = 0; i < DL; i++) begin
      n_chk++; if (vec[i] !== DW'(8'h60 + i)) begin n_fail++; $display("FAIL midrst_slot%0d: got %h want %h", i, vec[i], DW'(8'h60 + i)); end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_full(1'b0);
    test_short();
    test_single();
    test_full(1'b1);
    test_back_to_back();
    test_hold();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
